univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 8-cell serial-in/parallel-out chain in the user module. Adds:
- configurable width
- left/right shift, rotate and parallel load
- a shift counter
- an autonomous burst serialiser (start/busy/done) that clocks a loaded word out on ser_out

Sits between the pin-level I/O wrapper (ui_in/uo_out/uio) and any logic needing serial <-> parallel conversion.

Parameters:
WIDTH, 8, register length in bits; legal range 2..32
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)
CW, $clog2(WIDTH+1), bit_count width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active low
ena  in  1  global enable; low = every register holds
mode  in  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
rotate  in  1  1 = bit shifted out is fed back in place of ser_in
ser_in  in  1  serial fill bit
par_in  in  WIDTH  parallel load data
start  in  1  request burst serialisation (mode selects direction)
q  out  WIDTH  register contents
ser_out  out  1  last bit shifted out (registered)
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
bit_count  out  CW  shifts since last load/start/reset, saturating at WIDTH

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset state (rst_n low at an edge): q=RESET_VAL, ser_out=0, busy=0, done=0, bit_count=0, FSM=IDLE. Reset overrides ena and every other input, including mid-burst.
- ena=0: all registers, including FSM state and done, hold their values.
- Latency: one cycle. An operation applied before edge N is visible on q after edge N.
- Shift left:
  - q <= {q[WIDTH-2:0], fill}
  - ser_out <= q[WIDTH-1]
  - fill = rotate ? q[WIDTH-1] : ser_in
- Shift right:
  - q <= {fill, q[WIDTH-1:1]}
  - ser_out <= q[0]
  - fill = rotate ? q[0] : ser_in
- Parallel load: q <= par_in; bit_count <= 0; ser_out holds.
- Hold: nothing changes.
- bit_count: +1 per shift; saturates at WIDTH in manual mode.

FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Manual mode ops apply.
  - start=1 with mode 01 or 10 -> SHIFT. This edge latches the direction, clears bit_count and performs no shift.
  - start with mode 00 or 11 is ignored; the mode op itself still applies.
- SHIFT:
  - busy=1.
  - Each enabled cycle performs one shift in the latched direction (rotate/ser_in honoured live).
  - mode, par_in and start are ignored.
  - After the WIDTH-th shift (bit_count==WIDTH) -> DONE.
- DONE:
  - busy=0, done=1 for exactly one enabled cycle, then IDLE.
  - Manual mode ops and start are ignored in DONE.
- start asserted while busy or in DONE is dropped; it is not queued.

Optional Feature:
Macro UNIV_SHIFT_REG_PARITY_EN.
- Defined: extra output port parity (1 bit) = combinational XOR reduction of q. Reset value follows from RESET_VAL (0 for default).
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. WIDTH=8, reset, then mode=01, ser_in=1 for one cycle, then 0 for 8 cycles -> q=00000001, 00000010, …, 10000000, 00000000. ser_out=1 only after the 9th shift. bit_count saturates at 8.
2. Reset, mode=01, feed ser_in 1,0,1,1,0,1,1,0 -> q=8'hB6 (10110110); bit_count=8.
3. Load par_in=8'hA5 (mode=11), then mode=10, rotate=1 for 8 cycles -> q=8'hD2 after the first shift, 8'hA5 after the 8th; ser_out sequence 1,0,1,0,0,1,0,1.
4. Load 8'h3C, start=1 with mode=01, ser_in=0:
   - busy high for 8 cycles
   - ser_out sequence 0,0,1,1,1,1,0,0
   - done high exactly one cycle, then IDLE
   - final q=8'h00
   - start pulses during busy ignored
5. Burst started on 8'hFF. rst_n=0 after 3 shifts -> next cycle q=8'h00, busy=0, bit_count=0, and done never asserts. Afterwards, start with mode=11 -> no burst, q loads par_in.
6. Burst running, ena=0 for 3 cycles after shift 4 -> q, bit_count and busy frozen during the 3 cycles; done arrives 3 cycles later than nominal, with the same final q as an uninterrupted burst.

Source files
------------

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with burst serialiser (optional parity: UNIV_SHIFT_REG_PARITY_EN)
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    bit_count
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_d;
    logic             ser_d;
    logic [CW-1:0]    cnt_d;

    logic [WIDTH-1:0] q_left;
    logic [WIDTH-1:0] q_right;
    logic [CW-1:0]    cnt_sat;

    assign q_left  = {q[WIDTH-2:0], rotate ? q[WIDTH-1] : ser_in};
    assign q_right = {rotate ? q[0] : ser_in, q[WIDTH-1:1]};
    assign cnt_sat = (bit_count == CW'(WIDTH)) ? bit_count : bit_count + CW'(1);

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

`ifdef UNIV_SHIFT_REG_PARITY_EN
    assign parity = ^q;
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        q_d     = q;
        ser_d   = ser_out;
        cnt_d   = bit_count;
        case (state_q)
            S_IDLE: begin
                if (start && (mode == MODE_LEFT || mode == MODE_RIGHT)) begin
                    // The start edge only arms the burst; the first shift happens next cycle.
                    state_d = S_SHIFT;
                    dir_d   = (mode == MODE_RIGHT);
                    cnt_d   = '0;
                end else begin
                    case (mode)
                        MODE_LEFT: begin
                            q_d   = q_left;
                            ser_d = q[WIDTH-1];
                            cnt_d = cnt_sat;
                        end
                        MODE_RIGHT: begin
                            q_d   = q_right;
                            ser_d = q[0];
                            cnt_d = cnt_sat;
                        end
                        MODE_LOAD: begin
                            q_d   = par_in;
                            cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_SHIFT: begin
                q_d   = dir_q ? q_right : q_left;
                ser_d = dir_q ? q[0] : q[WIDTH-1];
                cnt_d = bit_count + CW'(1);
                if (bit_count == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            q         <= RESET_VAL;
            ser_out   <= 1'b0;
            bit_count <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            q         <= q_d;
            ser_out   <= ser_d;
            bit_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg with a behavioural reference model
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [1:0]   mode;
    logic         rotate;
    logic         ser_in;
    logic [W-1:0] par_in;
    logic         start;
    logic [W-1:0] q;
    logic         ser_out;
    logic         busy;
    logic         done;
    logic [3:0]   bit_count;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic         parity;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers, burst tracked as shifts remaining.
    int m_q, m_ser, m_cnt, m_left, m_done, m_dir;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .rotate(rotate),
        .ser_in(ser_in), .par_in(par_in), .start(start), .q(q),
        .ser_out(ser_out), .busy(busy), .done(done), .bit_count(bit_count)
`ifdef UNIV_SHIFT_REG_PARITY_EN
        , .parity(parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_shift(input int d);
        int v, outb, fill;
        v = m_q;
        if (d == 1) begin
            outb = v / 128;
            fill = rotate ? outb : int'(ser_in);
            v = (v * 2) % 256 + fill;
        end else begin
            outb = v % 2;
            fill = rotate ? outb : int'(ser_in);
            v = v / 2 + fill * 128;
        end
        m_ser = outb;
        m_q = v;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_q = 0; m_ser = 0; m_cnt = 0; m_left = 0; m_done = 0; m_dir = 1;
        end else if (ena) begin
            if (m_done != 0) begin
                m_done = 0;
            end else if (m_left > 0) begin
                model_shift(m_dir);
                m_cnt = m_cnt + 1;
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1;
            end else if (start && (mode == 2'd1 || mode == 2'd2)) begin
                m_left = W;
                m_dir = int'(mode);
                m_cnt = 0;
            end else if (mode == 2'd1 || mode == 2'd2) begin
                model_shift(int'(mode));
                if (m_cnt < W) m_cnt = m_cnt + 1;
            end else if (mode == 2'd3) begin
                m_q = int'(par_in);
                m_cnt = 0;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; ena = 1'b1; mode = 2'd0; rotate = 1'b0;
        ser_in = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; mode = 2'd3; rotate = 1'b1;
        ser_in = 1'b1; par_in = 8'hFF; start = 1'b1;
        step();
        checks++;
        if ({q, ser_out, busy, done, bit_count} !== {8'h00, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_state: got q=%h ser=%b busy=%b done=%b cnt=%0d, want q=00 ser=0 busy=0 done=0 cnt=0",
                     q, ser_out, busy, done, bit_count);
        end
        idle_inputs();
    endtask

    task automatic test_shift_left();
        logic [7:0] exp_q;
        do_reset();
        mode = 2'd1; ser_in = 1'b1;
        step();
        checks++;
        if (q !== 8'h01 || bit_count !== 4'd1) begin
            errors++;
            $display("FAIL shl_first: got q=%h cnt=%0d, want q=01 cnt=1", q, bit_count);
        end
        ser_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_q = (i < 8) ? 8'(1 << i) : 8'h00;
            checks++;
            if (q !== exp_q || ser_out !== (i == 8) || bit_count !== 4'((i + 1 > 8) ? 8 : i + 1)) begin
                errors++;
                $display("FAIL shl_walk[%0d]: got q=%h ser=%b cnt=%0d, want q=%h ser=%b cnt=%0d",
                         i, q, ser_out, bit_count, exp_q, (i == 8), (i + 1 > 8) ? 8 : i + 1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_serial_pattern();
        logic [7:0] pat;
        pat = 8'b10110110;
        do_reset();
        mode = 2'd1;
        for (int i = 7; i >= 0; i--) begin
            ser_in = pat[i];
            step();
        end
        checks++;
        if (q !== 8'hB6 || bit_count !== 4'd8) begin
            errors++;
            $display("FAIL serial_pattern: got q=%h cnt=%0d, want q=b6 cnt=8", q, bit_count);
        end
        idle_inputs();
    endtask

    task automatic test_rotate_right();
        logic [7:0] seq;
        seq = 8'b10100101;
        mode = 2'd3; par_in = 8'hA5;
        step();
        checks++;
        if (q !== 8'hA5 || bit_count !== 4'd0) begin
            errors++;
            $display("FAIL load: got q=%h cnt=%0d, want q=a5 cnt=0", q, bit_count);
        end
        mode = 2'd2; rotate = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (ser_out !== seq[7-i]) begin
                errors++;
                $display("FAIL ror_ser[%0d]: got %b, want %b", i, ser_out, seq[7-i]);
            end
            if (i == 0) begin
                checks++;
                if (q !== 8'hD2) begin
                    errors++;
                    $display("FAIL ror_first: got q=%h, want d2", q);
                end
            end
        end
        checks++;
        if (q !== 8'hA5) begin
            errors++;
            $display("FAIL ror_final: got q=%h, want a5", q);
        end
        idle_inputs();
    endtask

    task automatic test_burst();
        logic [7:0] exp_ser;
        int busy_cycles, done_at, k;
        exp_ser = 8'b00111100;
        mode = 2'd3; par_in = 8'h3C;
        step();
        mode = 2'd1; start = 1'b1; ser_in = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || bit_count !== 4'd0 || q !== 8'h3C) begin
            errors++;
            $display("FAIL burst_arm: got busy=%b cnt=%0d q=%h, want busy=1 cnt=0 q=3c", busy, bit_count, q);
        end
        busy_cycles = 1; done_at = -1; k = 0;
        for (int c = 1; c <= 12; c++) begin
            start = 1'($urandom); mode = 2'($urandom); par_in = 8'($urandom);
            step();
            checks++;
            if (ser_out !== exp_ser[7-k]) begin
                errors++;
                $display("FAIL burst_ser[%0d]: got %b, want %b", k, ser_out, exp_ser[7-k]);
            end
            k++;
            if (busy) busy_cycles++;
            if (done) begin
                done_at = c;
                break;
            end
        end
        checks++;
        if (done_at != 8 || busy_cycles != 8 || q !== 8'h00) begin
            errors++;
            $display("FAIL burst_done: got done_at=%0d busy_cycles=%0d q=%h, want 8 8 00", done_at, busy_cycles, q);
        end
        start = 1'b1; mode = 2'd1;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_after_done: got done=%b busy=%b, want 0 0", done, busy);
        end
        idle_inputs();
    endtask

    task automatic test_burst_reset();
        int done_seen;
        mode = 2'd3; par_in = 8'hFF;
        step();
        mode = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || bit_count !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL burst_reset: got q=%h busy=%b cnt=%0d done=%b, want 00 0 0 0", q, busy, bit_count, done);
        end
        idle_inputs();
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL burst_reset_done: got %0d done pulses, want 0", done_seen);
        end
        start = 1'b1; mode = 2'd3; par_in = 8'h5A;
        step();
        checks++;
        if (busy !== 1'b0 || q !== 8'h5A) begin
            errors++;
            $display("FAIL start_load: got busy=%b q=%h, want 0 5a", busy, q);
        end
        idle_inputs();
    endtask

    task automatic test_burst_ena();
        logic [7:0] w, q_frz;
        int done_at;
        w = 8'($urandom);
        mode = 2'd3; par_in = w;
        step();
        mode = 2'd1; rotate = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        q_frz = q;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q !== q_frz || bit_count !== 4'd4 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ena_freeze[%0d]: got q=%h cnt=%0d busy=%b, want q=%h cnt=4 busy=1",
                         i, q, bit_count, busy, q_frz);
            end
        end
        ena = 1'b1;
        done_at = -1;
        for (int c = 8; c <= 20; c++) begin
            step();
            if (done) begin
                done_at = c;
                break;
            end
        end
        checks++;
        if (done_at != 11 || q !== w) begin
            errors++;
            $display("FAIL ena_burst_done: got done_at=%0d q=%h, want 11 %h", done_at, q, w);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n  = ($urandom_range(0, 59) != 0);
            ena    = ($urandom_range(0, 5) != 0);
            mode   = 2'($urandom);
            rotate = 1'($urandom);
            ser_in = 1'($urandom);
            start  = ($urandom_range(0, 3) == 0);
            par_in = 8'($urandom);
            step();
            checks++;
            if ({q, ser_out, busy, done, bit_count} !==
                {8'(m_q), 1'(m_ser), (m_left > 0), 1'(m_done), 4'(m_cnt)}) begin
                errors++;
                $display("FAIL random[%0d]: got q=%h ser=%b busy=%b done=%b cnt=%0d, want q=%h ser=%0d busy=%0d done=%0d cnt=%0d",
                         i, q, ser_out, busy, done, bit_count, 8'(m_q), m_ser, (m_left > 0), m_done, m_cnt);
            end
`ifdef UNIV_SHIFT_REG_PARITY_EN
            checks++;
            if (parity !== ^(8'(m_q))) begin
                errors++;
                $display("FAIL parity[%0d]: got %b, want %b", i, parity, ^(8'(m_q)));
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        par_in = '0;
        test_reset();
        test_shift_left();
        test_serial_pattern();
        test_rotate_right();
        test_burst();
        test_burst_reset();
        test_burst_ena();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
